serial_chunk_adder: RTL and testbench

//  Multi-cycle adder. Adds two WIDTH-bit operands CHUNK bits per clock, LSB chunk first,

---
 rtl/serial_chunk_adder_if.sv | 53 +++++
 rtl/serial_chunk_adder.sv | 132 +++++++++++++
 tb/tb_serial_chunk_adder.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/serial_chunk_adder_if.sv
`default_nettype none
// ============================================================================
//  Module      : serial_chunk_adder_if
//  Description : Request/result bundle for serial_chunk_adder. The master side
//                issues start with operands; the slave side returns busy,
//                done and the held result. The sub line exists only when
//                SERIAL_CHUNK_ADDER_SUB_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
interface serial_chunk_adder_if #(
   parameter int WIDTH = 8
);
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
`ifdef SERIAL_CHUNK_ADDER_SUB_EN
   logic             sub;
`endif
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] sum;
   logic             cout;

   modport master (
      output start,
      output a,
      output b,
      output cin,
`ifdef SERIAL_CHUNK_ADDER_SUB_EN
      output sub,
`endif
      input  busy,
      input  done,
      input  sum,
      input  cout
   );

   modport slave (
      input  start,
      input  a,
      input  b,
      input  cin,
`ifdef SERIAL_CHUNK_ADDER_SUB_EN
      input  sub,
`endif
      output busy,
      output done,
      output sum,
      output cout
   );
endinterface
`default_nettype wire

// File: rtl/serial_chunk_adder.sv
`default_nettype none
// ============================================================================
//  Module      : serial_chunk_adder
//  Description : Multi-cycle adder. Adds two WIDTH-bit operands CHUNK bits per
//                clock, LSB chunk first, through a CHUNK-bit adder slice and a
//                registered carry. start/busy/done handshake; sum/cout are
//                held from the done pulse until the next accept.
//                Optional feature macro: SERIAL_CHUNK_ADDER_SUB_EN adds the
//                sub input (a - b via inverted B and forced carry-in).
//                WIDTH must be a multiple of CHUNK.
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_chunk_adder #(
   parameter int WIDTH = 8,
   parameter int CHUNK = 1
) (
   input  logic                clk,
   input  logic                rst_n,
   serial_chunk_adder_if.slave bus
);

   localparam int c_N     = WIDTH / CHUNK;
   localparam int c_CNT_W = (c_N > 1) ? $clog2(c_N) : 1;
   localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(c_N - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ADD  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t             r_state;
   logic [WIDTH-1:0]   r_a;
   logic [WIDTH-1:0]   r_b;
   logic [WIDTH-1:0]   r_res;
   logic [WIDTH-1:0]   r_sum;
   logic               r_carry;
   logic               r_cout;
   logic               r_busy;
   logic               r_done;
   logic [c_CNT_W-1:0] r_cnt;

   logic               w_accept;
   logic [WIDTH-1:0]   w_b_load;
   logic               w_c_load;
   logic [CHUNK:0]     w_slice;
   logic [WIDTH-1:0]   w_res_next;

   // A new operation is taken only while not busy (IDLE or the DONE cycle).
   assign w_accept = bus.start && ((r_state == ST_IDLE) || (r_state == ST_DONE));

   // Operand B and initial carry as loaded on accept; subtract folds into them.
`ifdef SERIAL_CHUNK_ADDER_SUB_EN
   assign w_b_load = bus.sub ? ~bus.b : bus.b;
   assign w_c_load = bus.sub ? 1'b1   : bus.cin;
`else
   assign w_b_load = bus.b;
   assign w_c_load = bus.cin;
`endif

   // One CHUNK-wide full-adder slice over the low chunk of the shift registers.
   assign w_slice = {1'b0, r_a[CHUNK-1:0]}
                  + {1'b0, r_b[CHUNK-1:0]}
                  + {{CHUNK{1'b0}}, r_carry};

   // New result chunk enters from the MSB side, older chunks move down.
   generate
      if (CHUNK == WIDTH) begin : g_res_single
         assign w_res_next = w_slice[CHUNK-1:0];
      end else begin : g_res_shift
         assign w_res_next = {w_slice[CHUNK-1:0], r_res[WIDTH-1:CHUNK]};
      end
   endgenerate

   // Control FSM and datapath registers; sum/cout commit only on the last step.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_a     <= '0;
         r_b     <= '0;
         r_res   <= '0;
         r_sum   <= '0;
         r_carry <= 1'b0;
         r_cout  <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_cnt   <= '0;
      end else begin
         case (r_state)
            ST_IDLE, ST_DONE: begin
               r_done <= 1'b0;
               if (w_accept) begin
                  r_a     <= bus.a;
                  r_b     <= w_b_load;
                  r_carry <= w_c_load;
                  r_cnt   <= '0;
                  r_busy  <= 1'b1;
                  r_state <= ST_ADD;
               end else begin
                  r_state <= ST_IDLE;
               end
            end
            ST_ADD: begin
               r_a     <= r_a >> CHUNK;
               r_b     <= r_b >> CHUNK;
               r_carry <= w_slice[CHUNK];
               r_res   <= w_res_next;
               r_cnt   <= r_cnt + 1'b1;
               if (r_cnt == c_LAST) begin
                  r_sum   <= w_res_next;
                  r_cout  <= w_slice[CHUNK];
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  r_state <= ST_DONE;
               end
            end
            default: begin
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.busy = r_busy;
   assign bus.done = r_done;
   assign bus.sum  = r_sum;
   assign bus.cout = r_cout;

endmodule
`default_nettype wire

// File: tb/tb_serial_chunk_adder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serial_chunk_adder
//  Description : Directed bench for serial_chunk_adder: a bit-serial WIDTH=8
//                instance and a CHUNK=4 instance sharing clock and reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_chunk_adder;

   logic clk;
   logic rst_n;

   serial_chunk_adder_if #(.WIDTH(8)) bus1 ();
   serial_chunk_adder_if #(.WIDTH(8)) bus4 ();

   serial_chunk_adder #(.WIDTH(8), .CHUNK(1)) dut1 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus1)
   );

   serial_chunk_adder #(.WIDTH(8), .CHUNK(4)) dut4 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   // Observation mux so one task can drive either instance.
   logic       sel4;
   logic       o_busy;
   logic       o_done;
   logic [7:0] o_sum;
   logic       o_cout;
   assign o_busy = sel4 ? bus4.busy : bus1.busy;
   assign o_done = sel4 ? bus4.done : bus1.done;
   assign o_sum  = sel4 ? bus4.sum  : bus1.sum;
   assign o_cout = sel4 ? bus4.cout : bus1.cout;

   logic [7:0] prev1;
   logic [7:0] prev4;
`ifdef SERIAL_CHUNK_ADDER_SUB_EN
   logic       sub_val;
`endif

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Issue one start pulse and check latency, held result and one-cycle done.
   task automatic run_op(input logic use4, input logic [7:0] ta, input logic [7:0] tb_v,
                         input logic tc, input logic [7:0] es, input logic ec,
                         input int elat, input string tag);
      int lat;
      sel4 = use4;
      if (use4) begin
         bus4.a = ta; bus4.b = tb_v; bus4.cin = tc; bus4.start = 1'b1;
`ifdef SERIAL_CHUNK_ADDER_SUB_EN
         bus4.sub = sub_val;
`endif
      end else begin
         bus1.a = ta; bus1.b = tb_v; bus1.cin = tc; bus1.start = 1'b1;
`ifdef SERIAL_CHUNK_ADDER_SUB_EN
         bus1.sub = sub_val;
`endif
      end
      @(negedge clk);
      bus1.start = 1'b0;
      bus4.start = 1'b0;
      check({tag, ".busy"}, {31'd0, o_busy}, 32'd1);
      check({tag, ".hold"}, {24'd0, o_sum}, {24'd0, use4 ? prev4 : prev1});
      lat = 0;
      while (!o_done && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      check({tag, ".lat"},  lat, elat);
      check({tag, ".sum"},  {24'd0, o_sum}, {24'd0, es});
      check({tag, ".cout"}, {31'd0, o_cout}, {31'd0, ec});
      check({tag, ".idle"}, {31'd0, o_busy}, 32'd0);
      @(negedge clk);
      check({tag, ".pulse"}, {31'd0, o_done}, 32'd0);
      if (use4) prev4 = es; else prev1 = es;
   endtask

   initial begin
      int cnt;
      int dcount;
      rst_n = 1'b0;
      sel4  = 1'b0;
      prev1 = 8'h00;
      prev4 = 8'h00;
      bus1.start = 1'b0; bus1.a = 8'h00; bus1.b = 8'h00; bus1.cin = 1'b0;
      bus4.start = 1'b0; bus4.a = 8'h00; bus4.b = 8'h00; bus4.cin = 1'b0;
`ifdef SERIAL_CHUNK_ADDER_SUB_EN
      sub_val  = 1'b0;
      bus1.sub = 1'b0;
      bus4.sub = 1'b0;
`endif
      repeat (2) @(negedge clk);
      check("rst.busy", {31'd0, bus1.busy}, 32'd0);
      check("rst.done", {31'd0, bus1.done}, 32'd0);
      check("rst.sum",  {24'd0, bus1.sum},  32'd0);
      check("rst.cout", {31'd0, bus1.cout}, 32'd0);
      check("rst4.sum", {24'd0, bus4.sum},  32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      run_op(1'b0, 8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0, 8, "add1");
      run_op(1'b0, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 8, "wrap");
      run_op(1'b0, 8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 8, "cinwrap");

      // start held through busy with changing operands: back-to-back accept.
      sel4 = 1'b0;
      bus1.a = 8'h12; bus1.b = 8'h34; bus1.cin = 1'b1; bus1.start = 1'b1;
      @(negedge clk);
      bus1.a = 8'h01; bus1.b = 8'h02; bus1.cin = 1'b0;
      cnt = 0;
      while (!bus1.done && cnt < 40) begin
         @(negedge clk);
         cnt++;
      end
      check("b2b.lat1",  cnt, 8);
      check("b2b.sum1",  {24'd0, bus1.sum},  32'h47);
      check("b2b.cout1", {31'd0, bus1.cout}, 32'd0);
      @(negedge clk);
      bus1.start = 1'b0;
      check("b2b.busy2", {31'd0, bus1.busy}, 32'd1);
      check("b2b.pulse", {31'd0, bus1.done}, 32'd0);
      cnt = 1;
      while (!bus1.done && cnt < 40) begin
         @(negedge clk);
         cnt++;
      end
      check("b2b.space", cnt, 9);
      check("b2b.sum2",  {24'd0, bus1.sum}, 32'h03);
      prev1 = 8'h03;
      @(negedge clk);

      // Reset during ADD step 4: outputs clear at once, no done afterwards.
      bus1.a = 8'hAA; bus1.b = 8'h55; bus1.cin = 1'b1; bus1.start = 1'b1;
      @(negedge clk);
      bus1.start = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("abort.busy", {31'd0, bus1.busy}, 32'd0);
      check("abort.done", {31'd0, bus1.done}, 32'd0);
      check("abort.sum",  {24'd0, bus1.sum},  32'd0);
      check("abort.cout", {31'd0, bus1.cout}, 32'd0);
      prev1 = 8'h00;
      prev4 = 8'h00;
      @(negedge clk);
      rst_n = 1'b1;
      dcount = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (bus1.done) dcount++;
      end
      check("abort.nodone", dcount, 0);
      run_op(1'b0, 8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 8, "after");

      run_op(1'b1, 8'h9C, 8'h78, 1'b0, 8'h14, 1'b1, 2, "chunk4");
      run_op(1'b1, 8'h0F, 8'hF0, 1'b1, 8'h00, 1'b1, 2, "chunk4c");

`ifdef SERIAL_CHUNK_ADDER_SUB_EN
      sub_val = 1'b1;
      run_op(1'b0, 8'h10, 8'h01, 1'b0, 8'h0F, 1'b1, 8, "sub1");
      run_op(1'b0, 8'h00, 8'h01, 1'b1, 8'hFF, 1'b0, 8, "sub2");
      sub_val = 1'b0;
      run_op(1'b0, 8'h10, 8'h01, 1'b0, 8'h11, 1'b0, 8, "sub0");
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
